// File: rtl/pipeline_hazard_controller_pkg.sv
// hazard_pkg: shared encodings and helpers for the pipeline hazard controller
//   HZ_*                  registered hazard class encodings (RUN/LOAD/DMISS/IMISS)
//   DATA_CACHE_LOAD_NONE  default "not a load" load-type code
//   sat_inc               increment that sticks at a caller-supplied maximum
package hazard_pkg;
   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_LOAD  = 2'd1,
      HZ_DMISS = 2'd2,
      HZ_IMISS = 2'd3
   } hz_state_e;
   localparam logic [2:0] DATA_CACHE_LOAD_NONE = 3'b000;
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
      return (v >= max_v) ? v : v + 64'd1;
   endfunction
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: pipeline <-> hazard controller signal bundle
//   master: pipeline side, drives cache-ready / EX operands / DM load info / branch
//   slave:  controller side, drives stall/clear controls, state and counters
//   load_use_hit: per-stage load-use hit vector, debug only
interface pipeline_hazard_controller_if #(
   parameter int REG_ADD_WIDTH    = 5,
   parameter int D_CACHE_LW_WIDTH = 3,
   parameter int LOAD_PIPE_DEPTH  = 3,
   parameter int CNT_WIDTH        = 32
);
   logic                                      INSTRUCTION_CACHE_READY;
   logic                                      DATA_CACHE_READY;
   logic [REG_ADD_WIDTH-1:0]                  RS1_ADDRESS_EXECUTION;
   logic [REG_ADD_WIDTH-1:0]                  RS2_ADDRESS_EXECUTION;
   logic                                      RS1_USED_EXECUTION;
   logic                                      RS2_USED_EXECUTION;
   logic [LOAD_PIPE_DEPTH*D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM;
   logic [LOAD_PIPE_DEPTH*REG_ADD_WIDTH-1:0]  RD_ADDRESS_DM;
   logic                                      BRANCH_TAKEN_EXECUTION;
   logic                                      STALL_PROGRAME_COUNTER_STAGE;
   logic                                      STALL_INSTRUCTION_CACHE;
   logic                                      STALL_INSTRUCTION_FETCH_STAGE;
   logic                                      STALL_DECODING_STAGE;
   logic                                      STALL_EXECUTION_STAGE;
   logic                                      STALL_DATA_MEMORY_STAGE;
   logic                                      CLEAR_INSTRUCTION_FETCH_STAGE;
   logic                                      CLEAR_DECODING_STAGE;
   logic                                      CLEAR_EXECUTION_STAGE;
   logic [1:0]                                HAZARD_STATE;
   logic [CNT_WIDTH-1:0]                      LOAD_STALL_COUNT;
   logic [CNT_WIDTH-1:0]                      CACHE_STALL_COUNT;
   logic [LOAD_PIPE_DEPTH-1:0]                load_use_hit;
   modport master (
      output INSTRUCTION_CACHE_READY, DATA_CACHE_READY, RS1_ADDRESS_EXECUTION, RS2_ADDRESS_EXECUTION,
             RS1_USED_EXECUTION, RS2_USED_EXECUTION, DATA_CACHE_LOAD_DM, RD_ADDRESS_DM, BRANCH_TAKEN_EXECUTION,
      input  STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_CACHE, STALL_INSTRUCTION_FETCH_STAGE,
             STALL_DECODING_STAGE, STALL_EXECUTION_STAGE, STALL_DATA_MEMORY_STAGE,
             CLEAR_INSTRUCTION_FETCH_STAGE, CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE,
             HAZARD_STATE, LOAD_STALL_COUNT, CACHE_STALL_COUNT, load_use_hit
   );
   modport slave (
      input  INSTRUCTION_CACHE_READY, DATA_CACHE_READY, RS1_ADDRESS_EXECUTION, RS2_ADDRESS_EXECUTION,
             RS1_USED_EXECUTION, RS2_USED_EXECUTION, DATA_CACHE_LOAD_DM, RD_ADDRESS_DM, BRANCH_TAKEN_EXECUTION,
      output STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_CACHE, STALL_INSTRUCTION_FETCH_STAGE,
             STALL_DECODING_STAGE, STALL_EXECUTION_STAGE, STALL_DATA_MEMORY_STAGE,
             CLEAR_INSTRUCTION_FETCH_STAGE, CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE,
             HAZARD_STATE, LOAD_STALL_COUNT, CACHE_STALL_COUNT, load_use_hit
   );
endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// load_use_detector: combinational load-use check of EX sources against DM1..DMn
//   rs1/rs2, rs1_used/rs2_used: EX-stage source registers and their use flags
//   load_dm, rd_dm: packed per-stage load codes / destinations, DM1 in the LSBs
//   lu: any stage hits; hit: per-stage hit vector
module load_use_detector import hazard_pkg::*; #(
   parameter int REG_ADD_WIDTH    = 5,
   parameter int D_CACHE_LW_WIDTH = 3,
   parameter logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_NONE = D_CACHE_LW_WIDTH'(hazard_pkg::DATA_CACHE_LOAD_NONE),
   parameter int LOAD_PIPE_DEPTH  = 3
) (
   input  logic [REG_ADD_WIDTH-1:0]                  rs1,
   input  logic [REG_ADD_WIDTH-1:0]                  rs2,
   input  logic                                      rs1_used,
   input  logic                                      rs2_used,
   input  logic [LOAD_PIPE_DEPTH*D_CACHE_LW_WIDTH-1:0] load_dm,
   input  logic [LOAD_PIPE_DEPTH*REG_ADD_WIDTH-1:0]  rd_dm,
   output logic                                      lu,
   output logic [LOAD_PIPE_DEPTH-1:0]                hit
);
   for (genvar k = 0; k < LOAD_PIPE_DEPTH; k++) begin : g_stage
      logic [REG_ADD_WIDTH-1:0] rd_k;
      assign rd_k   = rd_dm[k*REG_ADD_WIDTH +: REG_ADD_WIDTH];
      // x0 is hardwired zero, so a load targeting it never creates a dependency
      assign hit[k] = (load_dm[k*D_CACHE_LW_WIDTH +: D_CACHE_LW_WIDTH] != DATA_CACHE_LOAD_NONE) &&
                      (rd_k != '0) &&
                      ((rs1_used && rs1 == rd_k) || (rs2_used && rs2 == rd_k));
   end
   assign lu = |hit;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: per-stage stall/clear generation for the RISC-V pipeline
//   CLK, RST_N: rising-edge clock, asynchronous active-low reset
//   hz (slave): cache-ready, EX operands, DM load info and branch in;
//               stall/clear controls, registered hazard class and saturating stall counters out
module pipeline_hazard_controller import hazard_pkg::*; #(
   parameter int REG_ADD_WIDTH    = 5,
   parameter int D_CACHE_LW_WIDTH = 3,
   parameter logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_NONE = D_CACHE_LW_WIDTH'(hazard_pkg::DATA_CACHE_LOAD_NONE),
   parameter int LOAD_PIPE_DEPTH  = 3,
   parameter int CNT_WIDTH        = 32
) (
   input logic CLK,
   input logic RST_N,
   pipeline_hazard_controller_if.slave hz
);
   localparam logic [63:0] CNT_MAX = 64'({CNT_WIDTH{1'b1}});
   logic      lu, br, fp;
   hz_state_e cls, state;
   logic [CNT_WIDTH-1:0] load_cnt, cache_cnt;
   load_use_detector #(
      .REG_ADD_WIDTH(REG_ADD_WIDTH), .D_CACHE_LW_WIDTH(D_CACHE_LW_WIDTH),
      .DATA_CACHE_LOAD_NONE(DATA_CACHE_LOAD_NONE), .LOAD_PIPE_DEPTH(LOAD_PIPE_DEPTH)
   ) u_lud (
      .rs1(hz.RS1_ADDRESS_EXECUTION), .rs2(hz.RS2_ADDRESS_EXECUTION),
      .rs1_used(hz.RS1_USED_EXECUTION), .rs2_used(hz.RS2_USED_EXECUTION),
      .load_dm(hz.DATA_CACHE_LOAD_DM), .rd_dm(hz.RD_ADDRESS_DM),
      .lu(lu), .hit(hz.load_use_hit)
   );
   assign br  = hz.BRANCH_TAKEN_EXECUTION;
   assign cls = !hz.DATA_CACHE_READY        ? HZ_DMISS :
                lu                          ? HZ_LOAD  :
                !hz.INSTRUCTION_CACHE_READY ? HZ_IMISS : HZ_RUN;
   always_comb begin
      hz.STALL_PROGRAME_COUNTER_STAGE  = RST_N && (cls == HZ_DMISS || cls == HZ_LOAD || (cls == HZ_IMISS && !br));
      hz.STALL_INSTRUCTION_CACHE       = RST_N && cls != HZ_RUN;
      hz.STALL_INSTRUCTION_FETCH_STAGE = RST_N && cls != HZ_RUN;
      hz.STALL_DECODING_STAGE          = RST_N && (cls == HZ_DMISS || cls == HZ_LOAD);
      hz.STALL_EXECUTION_STAGE         = RST_N && (cls == HZ_DMISS || cls == HZ_LOAD);
      hz.STALL_DATA_MEMORY_STAGE       = RST_N && cls == HZ_DMISS;
      // a pending flush kills the stale wrong-path line on the first clean fetch cycle
      hz.CLEAR_INSTRUCTION_FETCH_STAGE = RST_N && ((cls == HZ_IMISS && br) || (cls == HZ_RUN && (br || fp)));
      hz.CLEAR_DECODING_STAGE          = RST_N && (cls == HZ_IMISS || (cls == HZ_RUN && br));
      hz.CLEAR_EXECUTION_STAGE         = RST_N && cls == HZ_LOAD;
   end
   assign hz.HAZARD_STATE      = state;
   assign hz.LOAD_STALL_COUNT  = load_cnt;
   assign hz.CACHE_STALL_COUNT = cache_cnt;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= HZ_RUN;
         fp        <= 1'b0;
         load_cnt  <= '0;
         cache_cnt <= '0;
      end else begin
         state <= cls;
         fp    <= (cls == HZ_IMISS && br) || (fp && cls != HZ_RUN);
         if (cls == HZ_LOAD)
            load_cnt <= CNT_WIDTH'(sat_inc(64'(load_cnt), CNT_MAX));
         if (cls == HZ_DMISS || cls == HZ_IMISS)
            cache_cnt <= CNT_WIDTH'(sat_inc(64'(cache_cnt), CNT_MAX));
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of stall/clear priority, flush, counters and depth
module tb_pipeline_hazard_controller;
   logic clk = 1'b0, rst_n = 1'b0;
   logic icr, dcr, u1, u2, br;
   logic [4:0]  rs1, rs2;
   logic [14:0] load;
   logic [24:0] rd;
   int total = 0, bad = 0;
   always #5 clk = ~clk;

   pipeline_hazard_controller_if #(.LOAD_PIPE_DEPTH(3), .CNT_WIDTH(4))  i3();
   pipeline_hazard_controller_if #(.LOAD_PIPE_DEPTH(1), .CNT_WIDTH(32)) i1();
   pipeline_hazard_controller_if #(.LOAD_PIPE_DEPTH(5), .CNT_WIDTH(32)) i5();

   pipeline_hazard_controller #(.LOAD_PIPE_DEPTH(3), .CNT_WIDTH(4))  u3 (.CLK(clk), .RST_N(rst_n), .hz(i3.slave));
   pipeline_hazard_controller #(.LOAD_PIPE_DEPTH(1), .CNT_WIDTH(32)) u1d (.CLK(clk), .RST_N(rst_n), .hz(i1.slave));
   pipeline_hazard_controller #(.LOAD_PIPE_DEPTH(5), .CNT_WIDTH(32)) u5 (.CLK(clk), .RST_N(rst_n), .hz(i5.slave));

   assign i3.INSTRUCTION_CACHE_READY = icr;  assign i3.DATA_CACHE_READY = dcr;
   assign i3.RS1_ADDRESS_EXECUTION = rs1;    assign i3.RS2_ADDRESS_EXECUTION = rs2;
   assign i3.RS1_USED_EXECUTION = u1;        assign i3.RS2_USED_EXECUTION = u2;
   assign i3.DATA_CACHE_LOAD_DM = load[8:0]; assign i3.RD_ADDRESS_DM = rd[14:0];
   assign i3.BRANCH_TAKEN_EXECUTION = br;
   assign i1.INSTRUCTION_CACHE_READY = icr;  assign i1.DATA_CACHE_READY = dcr;
   assign i1.RS1_ADDRESS_EXECUTION = rs1;    assign i1.RS2_ADDRESS_EXECUTION = rs2;
   assign i1.RS1_USED_EXECUTION = u1;        assign i1.RS2_USED_EXECUTION = u2;
   assign i1.DATA_CACHE_LOAD_DM = load[2:0]; assign i1.RD_ADDRESS_DM = rd[4:0];
   assign i1.BRANCH_TAKEN_EXECUTION = br;
   assign i5.INSTRUCTION_CACHE_READY = icr;  assign i5.DATA_CACHE_READY = dcr;
   assign i5.RS1_ADDRESS_EXECUTION = rs1;    assign i5.RS2_ADDRESS_EXECUTION = rs2;
   assign i5.RS1_USED_EXECUTION = u1;        assign i5.RS2_USED_EXECUTION = u2;
   assign i5.DATA_CACHE_LOAD_DM = load;      assign i5.RD_ADDRESS_DM = rd;
   assign i5.BRANCH_TAKEN_EXECUTION = br;

   // {stall pc, ic, if, dec, ex, dm, clear if, dec, ex}
   logic [8:0] o3, o1, o5;
   assign o3 = {i3.STALL_PROGRAME_COUNTER_STAGE, i3.STALL_INSTRUCTION_CACHE, i3.STALL_INSTRUCTION_FETCH_STAGE,
                i3.STALL_DECODING_STAGE, i3.STALL_EXECUTION_STAGE, i3.STALL_DATA_MEMORY_STAGE,
                i3.CLEAR_INSTRUCTION_FETCH_STAGE, i3.CLEAR_DECODING_STAGE, i3.CLEAR_EXECUTION_STAGE};
   assign o1 = {i1.STALL_PROGRAME_COUNTER_STAGE, i1.STALL_INSTRUCTION_CACHE, i1.STALL_INSTRUCTION_FETCH_STAGE,
                i1.STALL_DECODING_STAGE, i1.STALL_EXECUTION_STAGE, i1.STALL_DATA_MEMORY_STAGE,
                i1.CLEAR_INSTRUCTION_FETCH_STAGE, i1.CLEAR_DECODING_STAGE, i1.CLEAR_EXECUTION_STAGE};
   assign o5 = {i5.STALL_PROGRAME_COUNTER_STAGE, i5.STALL_INSTRUCTION_CACHE, i5.STALL_INSTRUCTION_FETCH_STAGE,
                i5.STALL_DECODING_STAGE, i5.STALL_EXECUTION_STAGE, i5.STALL_DATA_MEMORY_STAGE,
                i5.CLEAR_INSTRUCTION_FETCH_STAGE, i5.CLEAR_DECODING_STAGE, i5.CLEAR_EXECUTION_STAGE};

   localparam logic [8:0] V_DMISS = 9'h1F8, V_LOAD = 9'h1F1, V_IMISS = 9'h1C2, V_IMISS_BR = 9'h0C6,
                          V_RUN_BR = 9'h006, V_FLUSH = 9'h004, V_IDLE = 9'h000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int k, input logic [2:0] code, input logic [4:0] r);
      load = '0;
      rd   = '0;
      load[k*3 +: 3] = code;
      rd[k*5 +: 5]   = r;
   endtask

   initial begin
      icr = 1; dcr = 1; u1 = 0; u2 = 0; br = 0; rs1 = 0; rs2 = 0; load = '0; rd = '0;
      tick(); tick();
      rst_n = 1;
      tick();
      // D-miss then asynchronous reset in the middle of the stall
      dcr = 0; #1;
      chk("dmiss_out", 32'(o3), 32'(V_DMISS));
      tick();
      chk("dmiss_state", 32'(i3.HAZARD_STATE), 2);
      chk("dmiss_ccnt", 32'(i3.CACHE_STALL_COUNT), 1);
      rst_n = 0; #1;
      chk("rst_force", 32'(o3), 32'(V_IDLE));
      dcr = 1;
      tick();
      rst_n = 1; #1;
      chk("rst_state", 32'(i3.HAZARD_STATE), 0);
      chk("rst_lcnt", 32'(i3.LOAD_STALL_COUNT), 0);
      chk("rst_ccnt", 32'(i3.CACHE_STALL_COUNT), 0);
      // load-use on DM2 through rs2
      put(1, 3'b010, 5); rs2 = 5; u2 = 1; #1;
      chk("lu_out", 32'(o3), 32'(V_LOAD));
      tick();
      chk("lu_state", 32'(i3.HAZARD_STATE), 1);
      chk("lu_lcnt", 32'(i3.LOAD_STALL_COUNT), 1);
      put(1, 3'b010, 0); #1;
      chk("lu_rd0", 32'(o3), 32'(V_IDLE));
      put(1, 3'b010, 5); u2 = 0; #1;
      chk("lu_unused", 32'(o3), 32'(V_IDLE));
      // D-miss outranks a simultaneous load-use hit
      u2 = 1; dcr = 0; #1;
      chk("prio_out", 32'(o3), 32'(V_DMISS));
      tick();
      chk("prio_state", 32'(i3.HAZARD_STATE), 2);
      chk("prio_ccnt", 32'(i3.CACHE_STALL_COUNT), 1);
      chk("prio_lcnt", 32'(i3.LOAD_STALL_COUNT), 1);
      dcr = 1; u2 = 0; load = '0; rd = '0;
      tick();
      chk("run_state", 32'(i3.HAZARD_STATE), 0);
      // taken branch in the first of four I-miss cycles
      icr = 0;
      for (int i = 0; i < 4; i++) begin
         br = (i == 0); #1;
         chk($sformatf("imiss_c%0d", i + 1), 32'(o3), 32'(i == 0 ? V_IMISS_BR : V_IMISS));
         tick();
      end
      br = 0;
      chk("imiss_state", 32'(i3.HAZARD_STATE), 3);
      chk("imiss_ccnt", 32'(i3.CACHE_STALL_COUNT), 5);
      icr = 1; #1;
      chk("flush_first", 32'(o3), 32'(V_FLUSH));
      tick();
      chk("flush_done", 32'(o3), 32'(V_IDLE));
      br = 1; #1;
      chk("run_br", 32'(o3), 32'(V_RUN_BR));
      // branch is ignored while a load-use stall holds it in EX
      put(1, 3'b010, 5); u2 = 1; #1;
      chk("lu_br", 32'(o3), 32'(V_LOAD));
      br = 0;
      // LOAD_STALL_COUNT (4 bits) starts at 1 and must stop at 15
      for (int i = 0; i < 10; i++) tick();
      chk("sat_mid", 32'(i3.LOAD_STALL_COUNT), 11);
      for (int i = 0; i < 10; i++) tick();
      chk("sat_end", 32'(i3.LOAD_STALL_COUNT), 15);
      chk("sat_ccnt", 32'(i3.CACHE_STALL_COUNT), 5);
      // depth sweep via rs1 = 7
      u2 = 0; rs2 = 0; u1 = 1; rs1 = 7;
      put(0, 3'b010, 7); #1;
      chk("d1_last", 32'(o1), 32'(V_LOAD));
      put(1, 3'b010, 7); #1;
      chk("d1_oor", 32'(o1), 32'(V_IDLE));
      chk("d5_dm2", 32'(o5), 32'(V_LOAD));
      put(4, 3'b010, 7); #1;
      chk("d5_last", 32'(o5), 32'(V_LOAD));
      chk("d3_dm5", 32'(o3), 32'(V_IDLE));
      put(3, 3'b010, 7); #1;
      chk("d3_oor", 32'(o3), 32'(V_IDLE));
      put(2, 3'b010, 7); #1;
      chk("d3_last", 32'(o3), 32'(V_LOAD));
      put(2, 3'b000, 7); #1;
      chk("d3_noload", 32'(o3), 32'(V_IDLE));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
